// File: rtl/alu_seq.sv
// alu_seq: valid/ready sequential ALU. Single-cycle operations complete on the accept edge;
// MUL runs an iterative shift-add multiplier for WIDTH cycles before presenting its result.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             a_is_zero,
    output logic             carry,
    output logic             illegal
);

    localparam logic [3:0] OP_HLT = 4'd0;
    localparam logic [3:0] OP_SKZ = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LDA = 4'd5;
    localparam logic [3:0] OP_STO = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_SUB = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_out_q;
    logic             carry_q;
    logic             a_is_zero_q;
    logic             illegal_q;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    iter_q;
    logic             az_pend_q;

    logic             in_ready_s;
    logic             accept_s;
    logic             is_mul_s;
    logic             eval_ill_s;
    logic             eval_c_s;
    logic [WIDTH-1:0] eval_res_s;
    logic [WIDTH-1:0] acc_d;

    // Single-cycle operations; returns {illegal, carry, result}. MUL never lands here when enabled.
    function automatic logic [WIDTH+1:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             ill;
        sum = {1'b0, a} + {1'b0, b};
        r   = '0;
        c   = 1'b0;
        ill = 1'b0;
        case (op)
            OP_HLT, OP_SKZ, OP_STO, OP_JMP: r = a;
            OP_ADD: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
            end
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            OP_LDA: r = b;
            OP_SUB: begin
                r = a - b;
                c = (a < b);
            end
            OP_OR:  r = a | b;
            OP_SHL: begin
                r = {a[WIDTH-2:0], 1'b0};
                c = a[WIDTH-1];
            end
            OP_SHR: begin
                r = {1'b0, a[WIDTH-1:1]};
                c = a[0];
            end
            default: ill = 1'b1;
        endcase
        return {ill, c, r};
    endfunction

    // Handshake decode, single-cycle datapath and one multiplier step
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_q == ST_HOLD) begin
            in_ready_s = out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
        is_mul_s = MUL_EN && (opcode == OP_MUL);
        {eval_ill_s, eval_c_s, eval_res_s} = alu_eval(opcode, in_a, in_b);
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Control FSM with registered result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            carry_q     <= 1'b0;
            a_is_zero_q <= 1'b0;
            illegal_q   <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            iter_q      <= '0;
            az_pend_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s && is_mul_s) begin
                        state_q     <= ST_BUSY;
                        out_valid_q <= 1'b0;
                        mcand_q     <= in_a;
                        mplier_q    <= in_b;
                        acc_q       <= '0;
                        iter_q      <= '0;
                        az_pend_q   <= (in_a == '0);
                    end else if (accept_s) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        alu_out_q   <= eval_res_s;
                        carry_q     <= eval_c_s;
                        illegal_q   <= eval_ill_s;
                        a_is_zero_q <= (in_a == '0);
                    end else if (state_q == ST_HOLD && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end else begin
                        state_q     <= state_q;
                    end
                end
                ST_BUSY: begin
                    // Last step folds its partial product straight into the result register
                    if (iter_q == LAST_ITER) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        alu_out_q   <= acc_d;
                        carry_q     <= 1'b0;
                        illegal_q   <= 1'b0;
                        a_is_zero_q <= az_pend_q;
                        iter_q      <= '0;
                    end else begin
                        iter_q      <= iter_q + 1'b1;
                    end
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign carry     = carry_q;
    assign a_is_zero = a_is_zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8, MUL_EN=1): directed scenarios followed by random traffic
// checked against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         a_is_zero;
    logic         carry;
    logic         illegal;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         az;
        logic         ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   xfer_cnt = 0;
    int   rdy_pct = 100;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .a_is_zero (a_is_zero),
        .carry     (carry),
        .illegal   (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer arithmetic on the opcode table
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a8, input logic [W-1:0] b8);
        longint a, b, m, s;
        exp_t   e;
        a = longint'(a8);
        b = longint'(b8);
        m = (64'sd1 <<< W) - 64'sd1;
        e = '0;
        e.az = (a == 64'sd0);
        case (int'(op))
            0, 1, 6, 7: e.res = W'(a);
            2: begin
                s = a + b;
                e.res = W'(s & m);
                e.c = (s > m);
            end
            3: e.res = W'(a & b);
            4: e.res = W'(a ^ b);
            5: e.res = W'(b);
            8: begin
                e.res = W'((a - b) & m);
                e.c = (a < b);
            end
            9: e.res = W'(a | b);
            10: begin
                e.res = W'((a * 64'sd2) & m);
                e.c = (a * 64'sd2 > m);
            end
            11: begin
                e.res = W'(a / 64'sd2);
                e.c = (a % 64'sd2) != 64'sd0;
            end
            12: e.res = W'((a * b) & m);
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one request until accepted; pushes its expected result on the accepting cycle
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        opcode = op;
        in_a = a;
        in_b = b;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                sb.push_back(model(op, a, b));
                acc = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // out_ready generator, applied just after the active edge
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: pops and compares on every transfer, checks hold stability and reset effect
    initial begin
        logic         prev_stall;
        logic         prev_rst;
        logic [W+2:0] prev_vals;
        exp_t         e;
        prev_stall = 1'b0;
        prev_rst = 1'b1;
        prev_vals = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("in_ready_in_reset", in_ready, 0);
            end
            if (prev_rst) begin
                check("out_valid_after_reset", out_valid, 0);
            end else if (prev_stall) begin
                check("hold_stable", {out_valid, alu_out, carry, a_is_zero, illegal}, {1'b1, prev_vals});
            end
            if (!rst && out_valid && out_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", {alu_out, carry, a_is_zero, illegal}, e);
                end
            end
            prev_stall = out_valid && !out_ready && !rst;
            prev_vals  = {alu_out, carry, a_is_zero, illegal};
            prev_rst   = rst;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int first_valid;
        int low_cnt;
        int x0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        opcode = 4'd0;
        step(3);
        @(negedge clk);
        check("reset_outputs", {out_valid, alu_out, carry, a_is_zero, illegal}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);

        // ADD with carry, latency one cycle
        rdy_pct = 100;
        issue(4'd2, 8'hF0, 8'h20, w);
        @(negedge clk);
        check("add_latency_valid", out_valid, 1);
        @(posedge clk);
        #1;
        drain();

        // MUL timing: in_ready low for WIDTH cycles, result in cycle WIDTH+1
        issue(4'd12, 8'h0D, 8'h0B, w);
        first_valid = 0;
        low_cnt = 0;
        for (int c = 1; c <= 40 && first_valid == 0; c++) begin
            @(negedge clk);
            if (out_valid) first_valid = c;
            else if (!in_ready) low_cnt++;
        end
        check("mul_valid_cycle", first_valid, 9);
        check("mul_ready_low_cycles", low_cnt, 8);
        @(posedge clk);
        #1;
        drain();

        // Back-to-back SUB then LDA
        issue(4'd8, 8'h05, 8'h07, w);
        issue(4'd5, 8'h99, 8'h3C, w);
        check("b2b_second_wait", w, 0);
        @(negedge clk);
        check("b2b_second_valid", out_valid, 1);
        @(posedge clk);
        #1;
        drain();

        // Backpressure: result held, in_ready low, exactly one transfer
        rdy_pct = 0;
        step(1);
        x0 = xfer_cnt;
        issue(4'd4, 8'hAA, 8'h0F, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_held_value", {out_valid, alu_out}, {1'b1, 8'hA5});
        end
        check("bp_no_transfer", xfer_cnt - x0, 0);
        @(posedge clk);
        #1;
        rdy_pct = 100;
        drain();
        step(3);
        check("bp_single_transfer", xfer_cnt - x0, 1);

        // Illegal opcode with zero operand
        issue(4'd14, 8'h00, 8'h5A, w);
        drain();

        // Reset on the 4th busy cycle of a MUL
        x0 = xfer_cnt;
        issue(4'd12, 8'hFF, 8'hFF, w);
        step(3);
        rst = 1'b1;
        sb.delete();
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_idle_ready", {out_valid, in_ready}, {1'b0, 1'b1});
        @(posedge clk);
        #1;
        step(20);
        check("rst_busy_no_result", xfer_cnt - x0, 0);

        // Reset while a result is held
        rdy_pct = 0;
        step(1);
        issue(4'd3, 8'h3C, 8'h0F, w);
        step(2);
        rst = 1'b1;
        sb.delete();
        step(1);
        rst = 1'b0;
        rdy_pct = 100;
        step(5);
        check("rst_hold_no_result", xfer_cnt - x0, 0);

        // Random traffic with random backpressure
        rdy_pct = 70;
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = ($urandom_range(7) == 0) ? 8'h00 : W'($urandom);
            rb = W'($urandom);
            issue(4'($urandom_range(15)), ra, rb, w);
            if ($urandom_range(3) == 0) step(1);
        end
        rdy_pct = 100;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
